// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and defaults for the UART TX arbiter
package uart_arb_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   localparam int BYTE_W        = 8;
   localparam int DEF_MAX_BURST = 64;
   localparam int DEF_TIMEOUT   = 1024;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting after last_owner
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int OW      = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [OW-1:0]      last_owner,
   output logic [NUM_REQ-1:0] pick_onehot,
   output logic [OW-1:0]      pick_idx,
   output logic               pick_any
);

   int cand;

   // Scan last_owner+1 .. last_owner+NUM_REQ so the previous owner is considered last.
   always_comb begin
      pick_onehot = '0;
      pick_idx    = '0;
      pick_any    = 1'b0;
      cand        = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(last_owner) + k) % NUM_REQ;
         if (!pick_any && valid[cand]) begin
            pick_any          = 1'b1;
            pick_idx          = OW'(cand);
            pick_onehot[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-granular arbiter sharing one UART TX byte port
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int MAX_BURST = DEF_MAX_BURST,
   parameter int TIMEOUT   = DEF_TIMEOUT
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [BYTE_W*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      tx_valid,
   output logic [BYTE_W-1:0]         tx_data,
   input  logic                      tx_ready,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy
);

   localparam int OW = idx_w(NUM_REQ);
   localparam int IW = $clog2(TIMEOUT);

   state_t              state, state_nx;
   logic [NUM_REQ-1:0]  grant_q;
   logic [OW-1:0]       owner, last_owner;
   logic [7:0]          burst_cnt;
   logic [IW-1:0]       idle_cnt;

   logic [NUM_REQ-1:0]  pick_onehot;
   logic [OW-1:0]       pick_idx;
   logic                pick_any;

   logic [BYTE_W-1:0]   data_arr [NUM_REQ];
   logic                locked, own_valid, own_last, beat;
   logic                burst_done, idle_done, release_ev;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .OW      (OW)
   ) u_pick (
      .valid       (req_valid),
      .last_owner  (last_owner),
      .pick_onehot (pick_onehot),
      .pick_idx    (pick_idx),
      .pick_any    (pick_any)
   );

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         data_arr[i] = req_data[i*BYTE_W +: BYTE_W];
      end
   end

   assign locked     = (state == ST_LOCKED);
   assign own_valid  = req_valid[owner];
   assign own_last   = req_last[owner];
   assign beat       = locked & own_valid & tx_ready;
   assign burst_done = (burst_cnt == 8'(MAX_BURST - 1));
   assign idle_done  = (idle_cnt == IW'(TIMEOUT - 1));
   // Last-byte and burst limit on the same beat collapse into one release.
   assign release_ev = locked & ((beat & (own_last | burst_done)) | (~own_valid & idle_done));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (pick_any)   state_nx = ST_LOCKED;
         ST_LOCKED: if (release_ev) state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = locked;
      grant     = grant_q;
      tx_valid  = locked & own_valid;
      tx_data   = locked ? data_arr[owner] : '0;
      req_ready = (locked & tx_ready) ? grant_q : '0;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         grant_q    <= '0;
         owner      <= '0;
         last_owner <= OW'(NUM_REQ - 1);
         burst_cnt  <= '0;
         idle_cnt   <= '0;
      end else if (!locked) begin
         if (pick_any) begin
            grant_q   <= pick_onehot;
            owner     <= pick_idx;
            burst_cnt <= '0;
            idle_cnt  <= '0;
         end
      end else if (release_ev) begin
         grant_q    <= '0;
         last_owner <= owner;
         burst_cnt  <= '0;
         idle_cnt   <= '0;
      end else if (beat) begin
         burst_cnt <= burst_cnt + 8'd1;
         idle_cnt  <= '0;
      end else if (!own_valid) begin
         idle_cnt <= idle_cnt + IW'(1);
      end else begin
         // Owner valid but UART busy is a stall, not idleness.
         idle_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

   localparam int MB = 4;
   localparam int TO = 16;

   logic        CLK;
   logic        RST_N;
   logic [1:0]  req_valid, req_last, req_ready, grant;
   logic [15:0] req_data;
   logic        tx_valid, tx_ready, busy;
   logic [7:0]  tx_data;

   uart_tx_arbiter #(.NUM_REQ(2), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .grant     (grant),
      .busy      (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic       rst_n;
      logic [1:0] v, l;
      logic [7:0] d0, d1;
      logic       txr;
      logic [1:0] g;
      logic       tv;
      logic [7:0] td;
      logic [1:0] rr;
      logic       bz;
   } vec_t;

   vec_t tbl [8];

   int n_chk = 0;
   int n_fail = 0;

   int m_own, m_lo, m_burst, m_idle;
   logic [8:0] q0 [$];
   logic [8:0] q1 [$];
   logic [7:0] dut_log [$];
   logic [7:0] model_log [$];
   logic [7:0] exp_log [$];
   logic [1:0] en;
   logic       txr;
   bit         use_q;
   int         pause0, pause1;
   logic [1:0] a_grant, a_ready;
   logic       a_tv, a_busy;
   logic [7:0] a_td;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_own = -1; m_lo = 1; m_burst = 0; m_idle = 0;
   endtask

   task automatic model_release();
      m_lo = m_own; m_own = -1;
   endtask

   // Abstract reference: owner index (-1 = none), beats this grant, idle cycles so far.
   task automatic model_step();
      int o;
      if (m_own < 0) begin
         for (int k = 1; k <= 2; k++) begin
            o = (m_lo + k) % 2;
            if (m_own < 0 && req_valid[o]) begin
               m_own = o; m_burst = 0; m_idle = 0;
            end
         end
      end else begin
         o = m_own;
         if (req_valid[o] && tx_ready) begin
            model_log.push_back(req_data[o*8 +: 8]);
            if (use_q) begin
               if (o == 0) void'(q0.pop_front());
               else        void'(q1.pop_front());
            end
            m_burst++; m_idle = 0;
            if (req_last[o] || m_burst == MB) model_release();
         end else if (!req_valid[o]) begin
            m_idle++;
            if (m_idle == TO) model_release();
         end else begin
            m_idle = 0;
         end
      end
   endtask

   task automatic drive_q();
      req_valid[0]  = en[0] && (q0.size() > 0);
      req_valid[1]  = en[1] && (q1.size() > 0);
      req_data[7:0] = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      req_last[0]   = (q0.size() > 0) ? q0[0][8]   : 1'b0;
      req_data[15:8]= (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      req_last[1]   = (q1.size() > 0) ? q1[0][8]   : 1'b0;
      tx_ready      = txr;
   endtask

   task automatic cyc();
      logic [1:0] eg, er;
      logic       ev;
      logic [7:0] ed;
      @(negedge CLK);
      if (!RST_N) model_reset();
      eg = (m_own >= 0) ? 2'(1 << m_own) : 2'b00;
      ev = (m_own >= 0) && req_valid[m_own];
      ed = (m_own >= 0) ? req_data[m_own*8 +: 8] : 8'h00;
      er = (m_own >= 0 && tx_ready) ? eg : 2'b00;
      a_grant = grant; a_ready = req_ready; a_tv = tx_valid; a_td = tx_data; a_busy = busy;
      chk("grant", grant, eg);
      chk("tx_valid", tx_valid, ev);
      chk("tx_data", tx_data, ed);
      chk("req_ready", req_ready, er);
      chk("busy", busy, m_own >= 0);
      if (tx_valid && tx_ready) dut_log.push_back(tx_data);
      if (RST_N) model_step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      q0.delete(); q1.delete();
      en = 2'b11; txr = 1'b1;
      RST_N = 1'b0;
      drive_q(); cyc(); cyc();
      RST_N = 1'b1;
      dut_log.delete(); model_log.delete();
   endtask

   task automatic drain(input int maxc);
      int n;
      n = 0;
      while ((q0.size() + q1.size()) > 0 && n < maxc) begin
         drive_q(); cyc(); n++;
      end
      chk("drain_bound", (q0.size() + q1.size()) == 0, 1);
   endtask

   task automatic cmp_exp(input string nm);
      chk({nm, "_len"}, dut_log.size(), exp_log.size());
      for (int i = 0; i < dut_log.size() && i < exp_log.size(); i++)
         chk(nm, dut_log[i], exp_log[i]);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      RST_N = 1'b0; req_valid = '0; req_last = '0; req_data = '0; tx_ready = 1'b1;
      en = 2'b11; txr = 1'b1; use_q = 0; pause0 = 0; pause1 = 0;
      model_reset();

      // Reset with both valid, then "OK\n" from requester 0.
      tbl[0] = '{1'b0, 2'b11, 2'b00, 8'h4F, 8'h63, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0};
      tbl[1] = '{1'b0, 2'b11, 2'b00, 8'h4F, 8'h63, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0};
      tbl[2] = '{1'b1, 2'b01, 2'b00, 8'h4F, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0};
      tbl[3] = '{1'b1, 2'b01, 2'b00, 8'h4F, 8'h00, 1'b1, 2'b01, 1'b1, 8'h4F, 2'b01, 1'b1};
      tbl[4] = '{1'b1, 2'b01, 2'b00, 8'h4B, 8'h00, 1'b1, 2'b01, 1'b1, 8'h4B, 2'b01, 1'b1};
      tbl[5] = '{1'b1, 2'b01, 2'b01, 8'h0A, 8'h00, 1'b1, 2'b01, 1'b1, 8'h0A, 2'b01, 1'b1};
      tbl[6] = '{1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0};
      tbl[7] = '{1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0};
      for (int i = 0; i < 8; i++) begin
         RST_N = tbl[i].rst_n; req_valid = tbl[i].v; req_last = tbl[i].l;
         req_data = {tbl[i].d1, tbl[i].d0}; tx_ready = tbl[i].txr;
         cyc();
         chk("vec_grant", a_grant, tbl[i].g);
         chk("vec_tx_valid", a_tv, tbl[i].tv);
         chk("vec_tx_data", a_td, tbl[i].td);
         chk("vec_req_ready", a_ready, tbl[i].rr);
         chk("vec_busy", a_busy, tbl[i].bz);
      end
      use_q = 1;

      // Contention, two rounds: each message completes before the other starts.
      do_reset();
      for (int r = 0; r < 2; r++) begin
         dut_log.delete();
         q0.push_back({1'b0, 8'h41}); q0.push_back({1'b1, 8'h42});
         q1.push_back({1'b0, 8'h63}); q1.push_back({1'b1, 8'h64});
         drain(40);
         exp_log = '{8'h41, 8'h42, 8'h63, 8'h64};
         cmp_exp("contention");
      end

      // Burst limit forces a hand-over mid-stream.
      do_reset();
      for (int i = 0; i < 10; i++) q0.push_back({1'b0, 8'(8'h30 + i)});
      q1.push_back({1'b0, 8'h78}); q1.push_back({1'b1, 8'h79});
      drain(80);
      for (int i = 0; i < 20; i++) begin drive_q(); cyc(); end
      exp_log = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h78, 8'h79,
                  8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      cmp_exp("burst");
      chk("burst_timeout_grant", a_grant, 2'b00);

      // Idle timeout, then a long stall that must not time out.
      begin
         int held, stable;
         do_reset();
         q0.push_back({1'b0, 8'h55});
         drain(10);
         held = 0;
         for (int i = 0; i < 30; i++) begin
            drive_q(); cyc();
            if (a_grant == 2'b01) held++;
         end
         chk("timeout_cycles", held, TO);
         q0.push_back({1'b1, 8'hA5});
         txr = 1'b0;
         drive_q(); cyc();
         stable = 0;
         for (int i = 0; i < 100; i++) begin
            drive_q(); cyc();
            if (a_grant == 2'b01 && a_tv && a_td == 8'hA5) stable++;
         end
         chk("stall_held", stable, 100);
         txr = 1'b1;
         drive_q(); cyc();
         chk("stall_byte", a_td, 8'hA5);
         drive_q(); cyc();
         chk("stall_release", a_grant, 2'b00);
      end

      // Asynchronous reset in the middle of a 5-byte message.
      begin
         int n;
         do_reset();
         for (int i = 0; i < 5; i++) q0.push_back({1'(i == 4), 8'(8'h11 + i)});
         n = 0;
         while (model_log.size() < 2 && n < 20) begin drive_q(); cyc(); n++; end
         chk("mid_two_bytes", model_log.size(), 2);
         drive_q();
         #2;
         chk("pre_reset_valid", tx_valid, 1'b1);
         RST_N = 1'b0;
         #1;
         chk("async_tx_valid", tx_valid, 1'b0);
         chk("async_grant", grant, 2'b00);
         chk("async_ready", req_ready, 2'b00);
         chk("async_busy", busy, 1'b0);
         cyc(); cyc();
         q1.push_back({1'b1, 8'hEE});
         RST_N = 1'b1;
         drive_q(); cyc();
         drive_q(); cyc();
         chk("post_reset_owner", a_grant, 2'b01);
         drain(40);
         exp_log = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'hEE};
         cmp_exp("mid_reset");
      end

      // Randomised traffic against the reference model.
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         if (q0.size() < 6 && $urandom_range(0, 3) == 0)
            q0.push_back({1'($urandom_range(0, 3) == 0), 8'($urandom)});
         if (q1.size() < 6 && $urandom_range(0, 3) == 0)
            q1.push_back({1'($urandom_range(0, 3) == 0), 8'($urandom)});
         if (pause0 > 0) pause0--;
         else if ($urandom_range(0, 39) == 0) pause0 = $urandom_range(10, 25);
         if (pause1 > 0) pause1--;
         else if ($urandom_range(0, 39) == 0) pause1 = $urandom_range(10, 25);
         en  = {pause1 == 0, pause0 == 0};
         txr = ($urandom_range(0, 9) < 7);
         drive_q(); cyc();
      end
      chk("rand_log_len", dut_log.size(), model_log.size());
      for (int i = 0; i < dut_log.size() && i < model_log.size(); i++)
         chk("rand_log", dut_log[i], model_log[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
